uart_decode_packer: RTL and testbench

Downstream stage of the UART stream receiver in the logic-analyzer protocol-analyze path. Timestamps each decoded byte (i_rx_data/i_rx_valid) and buffers it in an internal FIFO. Emits 32-bit framed records on a valid/ready stream toward the Ethernet upload path. A frame is emitted when a full batch accumulates, on idle timeout, or on explicit flush.

---
 rtl/uart_decode_packer_if.sv | 27 ++
 rtl/uart_decode_packer.sv | 192 +++++++++++++++++++
 tb/tb_uart_decode_packer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_decode_packer_if.sv
`default_nettype none
// ============================================================
// Interface : uart_decode_packer_if
// Purpose   : 32-bit framed-record valid/ready stream
// Rev       : 1.0
// ============================================================
interface uart_decode_packer_if;
  logic [31:0] o_m_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic        o_m_last;

  modport master (
    output o_m_data,
    output o_m_valid,
    output o_m_last,
    input  i_m_ready
  );

  modport slave (
    input  o_m_data,
    input  o_m_valid,
    input  o_m_last,
    output i_m_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_decode_packer.sv
`default_nettype none
// ============================================================
// Module  : uart_decode_packer
// Purpose : timestamps decoded UART bytes, buffers them in a FIFO
//           and emits header-prefixed frames on a valid/ready stream
// Rev     : 1.0
// ============================================================
module uart_decode_packer #(
  parameter int          P_FIFO_AW   = 6,
  parameter int          P_PKT_WORDS = 16,
  parameter int          P_TIMEOUT   = 50000,
  parameter logic [15:0] P_HEADER    = 16'hA55A
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  input  logic                        i_flush,
  uart_decode_packer_if.master        m_if,
  output logic [15:0]                 o_drop_cnt,
  output logic                        o_busy
);

  localparam int                  C_DEPTH     = 1 << P_FIFO_AW;
  localparam int                  C_TMO_W     = $clog2(P_TIMEOUT);
  localparam logic [P_FIFO_AW:0]  C_DEPTH_CNT = (P_FIFO_AW + 1)'(C_DEPTH);
  localparam logic [P_FIFO_AW:0]  C_PKT_CNT   = (P_FIFO_AW + 1)'(P_PKT_WORDS);
  localparam logic [7:0]          C_PKT_8     = 8'(P_PKT_WORDS);
  localparam logic [C_TMO_W-1:0]  C_TMO_LAST  = C_TMO_W'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [23:0]          ts_q, ts_d;
  logic [P_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_FIFO_AW:0]   count_q, count_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [C_TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]           sent_q, sent_d;
  logic [31:0]          m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;

  logic [31:0]          fifo_mem [C_DEPTH];
  logic [31:0]          rd_data;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 hs;
  logic                 start;
  logic                 ovf_clr;
  logic [7:0]           cnt_sel;

  // Acceptance looks only at the occupancy at the start of the cycle.
  assign push    = i_rx_valid && (count_q != C_DEPTH_CNT);
  assign drop    = i_rx_valid && (count_q == C_DEPTH_CNT);
  assign hs      = m_valid_q && m_if.i_m_ready;
  assign rd_data = fifo_mem[rd_ptr_q];
  assign cnt_sel = (count_q >= C_PKT_CNT) ? C_PKT_8 : 8'(count_q);
  assign start   = (count_q >= C_PKT_CNT) || (tmo_q == C_TMO_LAST) ||
                   (i_flush && (count_q != '0));

  always_comb begin
    ts_d       = ts_q + 24'd1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    // A drop coinciding with the header handshake must survive the clear.
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    frame_cnt_d = frame_cnt_q;
    sent_d      = sent_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    pop         = 1'b0;
    ovf_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        tmo_d     = (count_q == '0) ? '0 : tmo_q + 1'b1;
        if (start) begin
          state_d     = S_HEAD;
          tmo_d       = '0;
          frame_cnt_d = cnt_sel;
          // Overflow bit reflects the flag including a drop in this same cycle.
          m_data_d    = {P_HEADER, 7'b0, ovf_q | drop, cnt_sel};
          m_valid_d   = 1'b1;
        end
      end
      S_HEAD: begin
        if (hs) begin
          pop      = 1'b1;
          ovf_clr  = 1'b1;
          m_data_d = rd_data;
          m_last_d = (frame_cnt_q == 8'd1);
          sent_d   = 8'd1;
          state_d  = S_BODY;
        end
      end
      S_BODY: begin
        if (hs) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = S_IDLE;
          end else begin
            pop      = 1'b1;
            m_data_d = rd_data;
            sent_d   = sent_q + 8'd1;
            m_last_d = ((sent_q + 8'd1) == frame_cnt_q);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {ts_q, i_rx_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      frame_cnt_q <= '0;
      sent_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      frame_cnt_q <= frame_cnt_d;
      sent_q      <= sent_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_if.o_m_data  = m_data_q;
  assign m_if.o_m_valid = m_valid_q;
  assign m_if.o_m_last  = m_last_q;
  assign o_drop_cnt     = drop_cnt_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_decode_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module  : tb_uart_decode_packer
// Purpose : randomized self-checking bench for uart_decode_packer
// Rev     : 1.0
// ============================================================
module tb_uart_decode_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rxd_a = '0, rxd_b = '0;
  logic        rxv_a = 1'b0, rxv_b = 1'b0;
  logic        fl_a = 1'b0, fl_b = 1'b0;
  logic [15:0] drop_a, drop_b;
  logic        busy_a, busy_b;
  bit          rand_rdy = 1'b0;

  uart_decode_packer_if if_a ();
  uart_decode_packer_if if_b ();

  // a: default sizing; b: 64-record frames and a short idle timeout
  uart_decode_packer #(.P_FIFO_AW(6), .P_PKT_WORDS(16), .P_TIMEOUT(50000), .P_HEADER(16'hA55A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rxd_a), .i_rx_valid(rxv_a), .i_flush(fl_a),
    .m_if(if_a.master), .o_drop_cnt(drop_a), .o_busy(busy_a));

  uart_decode_packer #(.P_FIFO_AW(6), .P_PKT_WORDS(64), .P_TIMEOUT(100), .P_HEADER(16'hA55A)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rxd_b), .i_rx_valid(rxv_b), .i_flush(fl_b),
    .m_if(if_b.master), .o_drop_cnt(drop_b), .o_busy(busy_b));

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] cyc;
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  logic [31:0] exp_a[$], exp_b[$];
  logic [32:0] obs_a[$], obs_b[$];
  logic [31:0] ocyc_a[$], ocyc_b[$];
  int stalls_a = 0, bad_a = 0, stalls_b = 0, bad_b = 0;
  logic pv_a = 1'b0, pr_a = 1'b0, pl_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0, pl_b = 1'b0;
  logic [31:0] pd_a = '0, pd_b = '0;

  // Stream observer: logs handshakes and counts stall-stability violations.
  always @(negedge clk) begin
    if (rst) begin
      pv_a <= 1'b0;
      pv_b <= 1'b0;
    end else begin
      if (pv_a && !pr_a) begin
        stalls_a <= stalls_a + 1;
        if (!if_a.o_m_valid || if_a.o_m_data !== pd_a || if_a.o_m_last !== pl_a) bad_a <= bad_a + 1;
      end
      if (pv_b && !pr_b) begin
        stalls_b <= stalls_b + 1;
        if (!if_b.o_m_valid || if_b.o_m_data !== pd_b || if_b.o_m_last !== pl_b) bad_b <= bad_b + 1;
      end
      if (if_a.o_m_valid && if_a.i_m_ready) begin
        obs_a.push_back({if_a.o_m_last, if_a.o_m_data});
        ocyc_a.push_back(cyc);
      end
      if (if_b.o_m_valid && if_b.i_m_ready) begin
        obs_b.push_back({if_b.o_m_last, if_b.o_m_data});
        ocyc_b.push_back(cyc);
      end
      pv_a <= if_a.o_m_valid; pr_a <= if_a.i_m_ready; pd_a <= if_a.o_m_data; pl_a <= if_a.o_m_last;
      pv_b <= if_b.o_m_valid; pr_b <= if_b.i_m_ready; pd_b <= if_b.o_m_data; pl_b <= if_b.o_m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) if_a.i_m_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  // One-cycle byte strobe; the model records {timestamp, byte} if it should be kept.
  task automatic send(input int d, input logic [7:0] b, input bit keep);
    if (d == 0) begin
      rxd_a = b; rxv_a = 1'b1;
      if (keep) exp_a.push_back({cyc[23:0], b});
    end else begin
      rxd_b = b; rxv_b = 1'b1;
      if (keep) exp_b.push_back({cyc[23:0], b});
    end
    tick(1);
    rxv_a = 1'b0;
    rxv_b = 1'b0;
  endtask

  task automatic wait_obs(input int d, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (d == 0 && obs_a.size() >= n) break;
      if (d == 1 && obs_b.size() >= n) break;
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.i_m_ready = 1'b0;
    if_b.i_m_ready = 1'b0;
    tick(3);
    n_chk++;
    if ({if_a.o_m_valid, if_a.o_m_last, busy_a, if_b.o_m_valid, if_b.o_m_last, busy_b} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 000000",
        {if_a.o_m_valid, if_a.o_m_last, busy_a, if_b.o_m_valid, if_b.o_m_last, busy_b});
    end
    n_chk++;
    if (if_a.o_m_data !== 32'h0 || if_b.o_m_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0", if_a.o_m_data, if_b.o_m_data);
    end
    n_chk++;
    if (drop_a !== 16'h0 || drop_b !== 16'h0) begin
      n_fail++; $display("FAIL reset_drop: got %h/%h want 0", drop_a, drop_b);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_batch();
    logic [31:0] rec;
    obs_a.delete(); ocyc_a.delete(); exp_a.delete();
    if_a.i_m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(0, 8'(i), 1'b1);
      if (i != 15) tick(9);
    end
    wait_obs(0, 17, 300);
    n_chk++;
    if (obs_a.size() !== 17) begin
      n_fail++; $display("FAIL batch_words: got %0d want 17", obs_a.size());
    end else begin
      n_chk++;
      if (obs_a[0] !== {1'b0, 32'hA55A0010}) begin
        n_fail++; $display("FAIL batch_hdr: got %h want 0a55a0010", obs_a[0]);
      end
      for (int i = 1; i <= 16; i++) begin
        rec = exp_a.pop_front();
        n_chk++;
        if (obs_a[i] !== {(i == 16), rec} || obs_a[i][7:0] !== 8'(i - 1)) begin
          n_fail++; $display("FAIL batch_rec%0d: got %h want %h", i, obs_a[i], {(i == 16), rec});
        end
        if (i > 1) begin
          n_chk++;
          if (obs_a[i][31:8] - obs_a[i-1][31:8] !== 24'd10 || ocyc_a[i] !== ocyc_a[i-1] + 32'd1) begin
            n_fail++; $display("FAIL batch_spacing%0d: ts delta %0d cyc delta %0d want 10/1", i,
              obs_a[i][31:8] - obs_a[i-1][31:8], ocyc_a[i] - ocyc_a[i-1]);
          end
        end
      end
    end
    tick(2);
    n_chk++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL batch_busy: got %b want 0", busy_a);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w0;
    logic [31:0] rec;
    obs_b.delete(); ocyc_b.delete(); exp_b.delete();
    if_b.i_m_ready = 1'b1;
    w0 = cyc;
    for (int i = 0; i < 3; i++) begin
      send(1, 8'($urandom), 1'b1);
      tick($urandom_range(0, 15));
    end
    wait_obs(1, 4, 200);
    n_chk++;
    if (obs_b.size() !== 4) begin
      n_fail++; $display("FAIL tmo_words: got %0d want 4", obs_b.size());
    end else begin
      n_chk++;
      if (obs_b[0] !== {1'b0, 32'hA55A0003} || ocyc_b[0] !== w0 + 32'd101) begin
        n_fail++; $display("FAIL tmo_hdr: got %h at %0d want 0a55a0003 at %0d", obs_b[0], ocyc_b[0], w0 + 101);
      end
      for (int i = 1; i <= 3; i++) begin
        rec = exp_b.pop_front();
        n_chk++;
        if (obs_b[i] !== {(i == 3), rec}) begin
          n_fail++; $display("FAIL tmo_rec%0d: got %h want %h", i, obs_b[i], {(i == 3), rec});
        end
      end
    end
    tick(3);
  endtask

  task automatic test_random_ready();
    logic [31:0] rec;
    obs_a.delete(); ocyc_a.delete(); exp_a.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(0, 8'(i), 1'b1);
      if (i != 15) tick(9);
    end
    wait_obs(0, 17, 600);
    rand_rdy = 1'b0;
    if_a.i_m_ready = 1'b1;
    n_chk++;
    if (obs_a.size() !== 17 || obs_a[0] !== {1'b0, 32'hA55A0010}) begin
      n_fail++; $display("FAIL rnd_frame: got %0d words hdr %h want 17 / 0a55a0010", obs_a.size(),
        (obs_a.size() > 0) ? obs_a[0] : 33'h0);
    end else begin
      for (int i = 1; i <= 16; i++) begin
        rec = exp_a.pop_front();
        n_chk++;
        if (obs_a[i] !== {(i == 16), rec} || obs_a[i][7:0] !== 8'(i - 1) ||
            (i > 1 && obs_a[i][31:8] - obs_a[i-1][31:8] !== 24'd10)) begin
          n_fail++; $display("FAIL rnd_rec%0d: got %h want %h", i, obs_a[i], {(i == 16), rec});
        end
      end
    end
    n_chk++;
    if (stalls_a == 0 || bad_a !== 0) begin
      n_fail++; $display("FAIL rnd_stall: stalls %0d unstable %0d want >0 / 0", stalls_a, bad_a);
    end
    tick(3);
  endtask

  task automatic test_overflow();
    logic [31:0] rec;
    obs_b.delete(); ocyc_b.delete(); exp_b.delete();
    if_b.i_m_ready = 1'b0;
    for (int i = 0; i < 70; i++) send(1, 8'($urandom), i < 64);
    tick(2);
    n_chk++;
    if (drop_b !== 16'd6) begin
      n_fail++; $display("FAIL ovf_drops: got %0d want 6", drop_b);
    end
    n_chk++;
    if (if_b.o_m_valid !== 1'b1 || if_b.o_m_data !== 32'hA55A0140) begin
      n_fail++; $display("FAIL ovf_hdr: got v=%b %h want v=1 a55a0140", if_b.o_m_valid, if_b.o_m_data);
    end
    if_b.i_m_ready = 1'b1;
    wait_obs(1, 65, 300);
    n_chk++;
    if (obs_b.size() !== 65) begin
      n_fail++; $display("FAIL ovf_words: got %0d want 65", obs_b.size());
    end else begin
      for (int i = 1; i <= 64; i++) begin
        rec = exp_b.pop_front();
        n_chk++;
        if (obs_b[i] !== {(i == 64), rec}) begin
          n_fail++; $display("FAIL ovf_rec%0d: got %h want %h", i, obs_b[i], {(i == 64), rec});
        end
      end
    end
    tick(2);
    send(1, 8'($urandom), 1'b1);
    send(1, 8'($urandom), 1'b1);
    fl_b = 1'b1;
    tick(1);
    fl_b = 1'b0;
    wait_obs(1, 68, 50);
    n_chk++;
    if (obs_b.size() !== 68 || obs_b[65] !== {1'b0, 32'hA55A0002}) begin
      n_fail++; $display("FAIL ovf_next_hdr: got %0d words hdr %h want 68 / 0a55a0002", obs_b.size(),
        (obs_b.size() > 65) ? obs_b[65] : 33'h0);
    end else begin
      rec = exp_b.pop_front();
      n_chk++;
      if (obs_b[66] !== {1'b0, rec}) begin
        n_fail++; $display("FAIL ovf_next_rec1: got %h want %h", obs_b[66], {1'b0, rec});
      end
      rec = exp_b.pop_front();
      n_chk++;
      if (obs_b[67] !== {1'b1, rec}) begin
        n_fail++; $display("FAIL ovf_next_rec2: got %h want %h", obs_b[67], {1'b1, rec});
      end
    end
    n_chk++;
    if (bad_b !== 0 || drop_b !== 16'd6) begin
      n_fail++; $display("FAIL ovf_stable: unstable %0d drops %0d want 0 / 6", bad_b, drop_b);
    end
    tick(3);
  endtask

  task automatic test_flush();
    logic [31:0] f;
    logic [31:0] rec;
    int seen;
    obs_a.delete(); ocyc_a.delete(); exp_a.delete();
    if_a.i_m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(0, 8'($urandom), 1'b1);
      tick($urandom_range(0, 3));
    end
    f = cyc;
    fl_a = 1'b1;
    tick(1);
    fl_a = 1'b0;
    wait_obs(0, 6, 50);
    n_chk++;
    if (obs_a.size() !== 6 || obs_a[0] !== {1'b0, 32'hA55A0005} || ocyc_a[0] !== f + 32'd1) begin
      n_fail++; $display("FAIL flush_hdr: got %0d words hdr %h at %0d want 6 / 0a55a0005 at %0d",
        obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 33'h0, (ocyc_a.size() > 0) ? ocyc_a[0] : 32'h0, f + 1);
    end else begin
      for (int i = 1; i <= 5; i++) begin
        rec = exp_a.pop_front();
        n_chk++;
        if (obs_a[i] !== {(i == 5), rec}) begin
          n_fail++; $display("FAIL flush_rec%0d: got %h want %h", i, obs_a[i], {(i == 5), rec});
        end
      end
    end
    tick(3);
    fl_a = 1'b1;
    tick(1);
    fl_a = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (if_a.o_m_valid !== 1'b0 || busy_a !== 1'b0) seen++;
      tick(1);
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_empty: active cycles %0d want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] b;
    obs_b.delete(); ocyc_b.delete(); exp_b.delete();
    if_b.i_m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 8'($urandom), 1'b1);
    fl_b = 1'b1;
    tick(1);
    fl_b = 1'b0;
    tick(1);
    if_b.i_m_ready = 1'b1;
    tick(1);
    if_b.i_m_ready = 1'b0;
    tick(1);
    n_chk++;
    if (if_b.o_m_valid !== 1'b1 || busy_b !== 1'b1 || obs_b.size() !== 1) begin
      n_fail++; $display("FAIL mid_body: got v=%b busy=%b words=%0d want 1/1/1", if_b.o_m_valid, busy_b, obs_b.size());
    end
    rst = 1'b1;
    tick(1);
    n_chk++;
    if (if_b.o_m_valid !== 1'b0 || drop_b !== 16'h0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got v=%b drop=%0d busy=%b want 0/0/0", if_b.o_m_valid, drop_b, busy_b);
    end
    rst = 1'b0;
    obs_b.delete(); ocyc_b.delete(); exp_b.delete();
    if_b.i_m_ready = 1'b1;
    k = $urandom_range(3, 10);
    b = 8'($urandom);
    tick(k);
    send(1, b, 1'b1);
    fl_b = 1'b1;
    tick(1);
    fl_b = 1'b0;
    wait_obs(1, 2, 30);
    tick(5);
    n_chk++;
    if (obs_b.size() !== 2) begin
      n_fail++; $display("FAIL post_rst_words: got %0d want 2", obs_b.size());
    end else begin
      n_chk++;
      if (obs_b[0] !== {1'b0, 32'hA55A0001} || obs_b[1] !== {1'b1, 24'(k), b}) begin
        n_fail++; $display("FAIL post_rst_frame: got %h %h want 0a55a0001 %h", obs_b[0], obs_b[1], {1'b1, 24'(k), b});
      end
    end
  endtask

  initial begin
    if_a.i_m_ready = 1'b0;
    if_b.i_m_ready = 1'b0;
    test_reset();
    test_batch();
    test_timeout();
    test_random_ready();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
